// File: rtl/hc85_sweep_checker.sv
// hc85_sweep_checker: exhaustive sweep self-test for a 4-bit magnitude comparator; SWEEP_STOP_ON_FAIL_EN ends the sweep at the first mismatch
module hc85_sweep_checker #(
  parameter int WIDTH  = 4,
  parameter int SETTLE = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic [WIDTH-1:0] a_out,
  output logic [WIDTH-1:0] b_out,
  input  logic [2:0]       o_in,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [2*WIDTH:0] err_count,
  output logic             fail_valid,
  output logic [WIDTH-1:0] fail_a,
  output logic [WIDTH-1:0] fail_b
);
  localparam int CW = $clog2(SETTLE + 1);
  localparam logic [1:0] S_IDLE = 2'd0, S_SETTLE = 2'd1, S_CHECK = 2'd2, S_DONE = 2'd3;
  logic [1:0] state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, fa_q, fa_d, fb_q, fb_d;
  logic [2*WIDTH:0] err_q, err_d;
  logic fv_q, fv_d, mis, last, stop;
  logic [2:0] exp_o;
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    a_d = a_q;
    b_d = b_q;
    err_d = err_q;
    fv_d = fv_q;
    fa_d = fa_q;
    fb_d = fb_q;
    exp_o = {a_q > b_q, a_q == b_q, a_q < b_q};
    mis = o_in != exp_o;
    last = &{a_q, b_q};
`ifdef SWEEP_STOP_ON_FAIL_EN
    stop = last | mis;
`else
    stop = last;
`endif
    case (state_q)
      S_IDLE, S_DONE: if (start) begin
        state_d = S_SETTLE;
        cnt_d = '0;
        {a_d, b_d} = '0;
        err_d = '0;
        {fv_d, fa_d, fb_d} = '0;
      end
      S_SETTLE: begin
        cnt_d = (cnt_q == CW'(SETTLE - 1)) ? '0 : cnt_q + 1'b1;
        state_d = (cnt_q == CW'(SETTLE - 1)) ? S_CHECK : S_SETTLE;
      end
      default: begin
        if (mis) err_d = err_q + 1'b1;
        if (mis && !fv_q) {fv_d, fa_d, fb_d} = {1'b1, a_q, b_q};
        state_d = stop ? S_DONE : S_SETTLE;
        // B is the inner index, so one 2W-bit increment walks the pairs in order
        if (!stop) {a_d, b_d} = {a_q, b_q} + (2*WIDTH)'(1);
      end
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q <= '0;
      a_q <= '0;
      b_q <= '0;
      err_q <= '0;
      fv_q <= 1'b0;
      fa_q <= '0;
      fb_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      a_q <= a_d;
      b_q <= b_d;
      err_q <= err_d;
      fv_q <= fv_d;
      fa_q <= fa_d;
      fb_q <= fb_d;
    end
  end
  assign a_out = a_q;
  assign b_out = b_q;
  assign busy = (state_q == S_SETTLE) || (state_q == S_CHECK);
  assign done = state_q == S_DONE;
  assign pass = done && (err_q == '0);
  assign err_count = err_q;
  assign fail_valid = fv_q;
  assign fail_a = fa_q;
  assign fail_b = fb_q;
endmodule
